ram_seq_ctrl: RTL and testbench

//   Sequencer for the single-port 256x8 block RAM in the key/RAM/display demo.

---
 rtl/ram_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_seq_ctrl.sv
// -----------------------------------------------------------------------------
// ram_seq_ctrl
//
// Sequencer for the single-port block RAM of the key/RAM/display demo.
// Debounced key pulses (from key_filter) are turned into RAM access sweeps:
//   key1 : write sweep, every address 0..DEPTH-1 is written with data = address
//   key2 : read sweep, addresses are stepped in order and each one is held for
//          DWELL_CNT clocks so the 7-seg display is readable. A second key2
//          pauses the sweep and a third resumes it exactly where it stopped.
// key1 has priority over key2 when both arrive in the same clock.
//
// Optional feature (compile-time macro):
//   RAM_SEQ_AUTO_READ_EN  defined   : a finished write sweep rolls straight
//                                     into a read sweep from address 0.
//                         undefined : a finished write sweep returns to IDLE.
//
// Parameters:
//   ADDR_W     RAM address width
//   DATA_W     RAM data width
//   DEPTH      number of addresses swept (0..DEPTH-1), DEPTH <= 2**ADDR_W
//   DWELL_CNT  clocks each read address is held
//   CNT_W      dwell counter width, 2**CNT_W > DWELL_CNT
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   key1_flag  in   1-clk pulse: start write sweep
//   key2_flag  in   1-clk pulse: start / pause / resume read sweep
//   wr_en      out  RAM write enable
//   rd_en      out  RAM read enable
//   addr       out  RAM address
//   data       out  RAM write data (0 outside a write sweep)
//   busy       out  high while writing, reading or paused
//   wr_done    out  1-clk pulse on the clock after the last write
//
// Every output is a flop; the combinational block computes the next value of
// each output alongside the next state so they all change on the same edge.
// -----------------------------------------------------------------------------
module ram_seq_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int DWELL_CNT = 10_000_000,
  parameter int CNT_W     = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key1_flag,
  input  logic              key2_flag,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              wr_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DWELL_CNT - 1);

  // Where a completed write sweep lands.
`ifdef RAM_SEQ_AUTO_READ_EN
  localparam state_t POST_WRITE = S_READ;
`else
  localparam state_t POST_WRITE = S_IDLE;
`endif

  state_t            state,   state_nxt;
  logic [CNT_W-1:0]  cnt,     cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] data_nxt;
  logic              wr_en_nxt;
  logic              rd_en_nxt;
  logic              busy_nxt;
  logic              wr_done_nxt;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr    <= '0;
      data    <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr    <= addr_nxt;
      data    <= data_nxt;
      wr_en   <= wr_en_nxt;
      rd_en   <= rd_en_nxt;
      busy    <= busy_nxt;
      wr_done <= wr_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next output values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    addr_inc    = addr + 1'b1;
    data_nxt    = '0;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    wr_done_nxt = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (key1_flag) begin
          state_nxt = S_WRITE;
          addr_nxt  = '0;
          cnt_nxt   = '0;
          wr_en_nxt = 1'b1;
        end else if (key2_flag) begin
          state_nxt = S_READ;
          addr_nxt  = '0;
          cnt_nxt   = '0;
          rd_en_nxt = 1'b1;
        end
      end

      // Keys are deliberately not looked at: a write sweep always completes.
      S_WRITE: begin
        if (addr == LAST_ADDR) begin
          state_nxt   = POST_WRITE;
          addr_nxt    = '0;
          cnt_nxt     = '0;
          wr_done_nxt = 1'b1;
          rd_en_nxt   = (POST_WRITE == S_READ);
        end else begin
          addr_nxt  = addr_inc;
          data_nxt  = DATA_W'(addr_inc);
          wr_en_nxt = 1'b1;
        end
      end

      S_READ: begin
        if (key1_flag) begin
          state_nxt = S_WRITE;
          addr_nxt  = '0;
          cnt_nxt   = '0;
          wr_en_nxt = 1'b1;
        end else if (key2_flag) begin
          // Freeze addr and cnt untouched so the resume continues mid-dwell.
          state_nxt = S_PAUSE;
        end else begin
          rd_en_nxt = 1'b1;
          if (cnt == LAST_CNT) begin
            cnt_nxt  = '0;
            addr_nxt = (addr == LAST_ADDR) ? '0 : addr_inc;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      S_PAUSE: begin
        if (key1_flag) begin
          state_nxt = S_WRITE;
          addr_nxt  = '0;
          cnt_nxt   = '0;
          wr_en_nxt = 1'b1;
        end else if (key2_flag) begin
          state_nxt = S_READ;
          rd_en_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        addr_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_seq_ctrl
//
// Scoreboard bench for ram_seq_ctrl (DWELL_CNT shortened to 4).
// The driver applies one key pattern per clock and advances a behavioural
// model that tracks the sweep as "which write index" or "how many read clocks
// have elapsed"; the expected outputs for the next clock go into a queue.
// A separate monitor pops one entry per clock and compares it against the DUT.
// A small RAM model is attached to the outputs so read data can be checked
// against the address presented one clock earlier.
// -----------------------------------------------------------------------------
module tb_ram_seq_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int DWELL  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              key1_flag;
  logic              key2_flag;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              wr_done;

  ram_seq_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .DWELL_CNT(DWELL),
    .CNT_W    (CNT_W)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key1_flag(key1_flag),
    .key2_flag(key2_flag),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .data     (data),
    .busy     (busy),
    .wr_done  (wr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // RAM model fed by the DUT outputs
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [DATA_W-1:0] q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      q       <= '0;
    end else begin
      if (wr_en) begin
        mem[addr]     <= data;
        written[addr] <= 1'b1;
      end
      if (rd_en) q <= mem[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              wr_done;
  } obs_t;

  obs_t sb_q [$];
  int   n_vec = 0;
  int   n_mis = 0;
  logic mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got 0x%h expected 0x%h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.wr_en   = wr_en;
    o.rd_en   = rd_en;
    o.addr    = addr;
    o.data    = data;
    o.busy    = busy;
    o.wr_done = wr_done;
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: write progress as an index, read progress as the number
  // of read clocks elapsed (address = elapsed / DWELL, wrapping every sweep).
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_WRITE, M_READ, M_PAUSE} mode_t;

  mode_t             m_mode;
  int                m_w;
  int                m_p;
  logic              m_done;
  logic [ADDR_W-1:0] m_last_addr;

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_w         = 0;
    m_p         = 0;
    m_done      = 1'b0;
    m_last_addr = '0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o         = '0;
    o.wr_done = m_done;
    o.busy    = (m_mode != M_IDLE);
    case (m_mode)
      M_IDLE:  o.addr = m_last_addr;
      M_WRITE: begin
        o.wr_en = 1'b1;
        o.addr  = ADDR_W'(m_w);
        o.data  = DATA_W'(m_w % (1 << DATA_W));
      end
      M_READ: begin
        o.rd_en = 1'b1;
        o.addr  = ADDR_W'(m_p / DWELL);
      end
      M_PAUSE: o.addr = ADDR_W'(m_p / DWELL);
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic model_step(input logic k1, input logic k2);
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (k1)      begin m_mode = M_WRITE; m_w = 0; end
        else if (k2) begin m_mode = M_READ;  m_p = 0; end
      end
      M_WRITE: begin
        if (m_w == DEPTH - 1) begin
          m_done      = 1'b1;
          m_w         = 0;
          m_last_addr = '0;
`ifdef RAM_SEQ_AUTO_READ_EN
          m_mode = M_READ;
          m_p    = 0;
`else
          m_mode = M_IDLE;
`endif
        end else begin
          m_w++;
        end
      end
      M_READ: begin
        if (k1)      begin m_mode = M_WRITE; m_w = 0; end
        else if (k2) m_mode = M_PAUSE;
        else         m_p = (m_p + 1) % (DEPTH * DWELL);
      end
      M_PAUSE: begin
        if (k1)      begin m_mode = M_WRITE; m_w = 0; end
        else if (k2) m_mode = M_READ;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock of stimulus: keys are applied at the falling edge, the model
  // predicts the outputs after the next rising edge, and the keys drop again.
  task automatic tick(input logic k1, input logic k2);
    obs_t e;
    key1_flag = k1;
    key2_flag = k2;
    model_step(k1, k2);
    e = model_obs();
    m_last_addr = e.addr;
    sb_q.push_back(e);
    @(negedge clk);
    key1_flag = 1'b0;
    key2_flag = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic async_reset();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dut_obs()), 32'd0);
    sb_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one comparison per clock, 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  initial begin
    obs_t e;
    obs_t prev_e;
    logic prev_valid;
    prev_valid = 1'b0;
    prev_e     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outputs{wr,rd,addr,data,busy,done}", 32'(dut_obs()), 32'(e));
        if (prev_valid && prev_e.rd_en && written[prev_e.addr])
          check("ram_q_vs_prev_addr", 32'(q), 32'(prev_e.addr));
        prev_e     = e;
        prev_valid = 1'b1;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    rst_n     = 1'b0;
    key1_flag = 1'b0;
    key2_flag = 1'b0;
    mon_en    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(dut_obs()), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Quiet after reset release.
    repeat (1000) tick(1'b0, 1'b0);

    // Full write sweep from IDLE, then settle.
    tick(1'b1, 1'b0);
    repeat (DEPTH + 10) tick(1'b0, 1'b0);

    // Read sweep long enough to pass 254, 255, 0.
    tick(1'b0, 1'b1);
    repeat (DEPTH * DWELL + 40) tick(1'b0, 1'b0);

    // Pause at addr 7 with two clocks of dwell left, hold, then resume.
    for (int i = 0; i < 4 * DEPTH * DWELL; i++) begin
      if (m_mode == M_READ && m_p == 7 * DWELL + 2) break;
      tick(1'b0, 1'b0);
    end
    tick(1'b0, 1'b1);
    repeat (100) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0);

    // Both keys in the same clock during READ: key1 wins.
    tick(1'b1, 1'b1);
    // Key pulses during the write sweep must not disturb it.
    repeat (20) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (30) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    repeat (DEPTH) tick(1'b0, 1'b0);

    // Key1 while paused restarts a write sweep.
    tick(1'b0, 1'b1);
    repeat (9) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (DEPTH + 5) tick(1'b0, 1'b0);

    // Random key traffic.
    for (int i = 0; i < 5000; i++) begin
      r = int'($urandom_range(0, 199));
      tick(r < 3 || r == 199, (r >= 3 && r < 9) || r == 199);
    end

    // Reset in the middle of a read sweep.
    if (m_mode != M_READ) begin
      tick(1'b1, 1'b0);
      repeat (DEPTH + 2) tick(1'b0, 1'b0);
      if (m_mode != M_READ) tick(1'b0, 1'b1);
    end
    repeat (13) tick(1'b0, 1'b0);
    async_reset();
    repeat (50) tick(1'b0, 1'b0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
